// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single-precision multiplier with valid/ready handshake,
// pass-through tag and overflow/underflow/invalid flags; denormals flush to zero.
module fmul_pipe #(
   parameter int LATENCY = 3,
   parameter int TAG_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      op1,
   input  logic [31:0]      op2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [TAG_W-1:0] out_tag,
   output logic             ovf,
   output logic             udf,
   output logic             nv
);
   // kind: 0 finite nonzero, 1 zero, 2 inf, 3 invalid
   typedef struct packed {
      logic [1:0]        kind;
      logic              sign;
      logic signed [9:0] exp;
      logic [47:0]       prod;
      logic [TAG_W-1:0]  tag;
   } mid_t;

   logic              w_adv;
   logic [7:0]        w_e1, w_e2;
   logic              w_z1, w_z2, w_i1, w_i2, w_n1, w_n2;
   mid_t              w_mid_in, w_mid_out;
   logic              w_vld;
   logic [46:0]       w_norm;
   logic              w_up;
   logic [23:0]       w_rnd;
   logic signed [9:0] w_fexp;
   logic [31:0]       w_res;
   logic [2:0]        w_flg;

   assign w_adv    = !(out_valid && !out_ready);
   assign in_ready = w_adv;

   assign w_e1 = op1[30:23];
   assign w_e2 = op2[30:23];
   assign w_z1 = w_e1 == 8'h00;
   assign w_z2 = w_e2 == 8'h00;
   assign w_i1 = op1[30:0] == 31'h7F80_0000;
   assign w_i2 = op2[30:0] == 31'h7F80_0000;
   assign w_n1 = w_e1 == 8'hFF && op1[22:0] != 23'h0;
   assign w_n2 = w_e2 == 8'hFF && op2[22:0] != 23'h0;

   always_comb begin
      w_mid_in.kind = (w_n1 || w_n2 || (w_i1 && w_z2) || (w_i2 && w_z1)) ? 2'd3 :
                      (w_i1 || w_i2) ? 2'd2 : (w_z1 || w_z2) ? 2'd1 : 2'd0;
      w_mid_in.sign = op1[31] ^ op2[31];
      w_mid_in.exp  = 10'(w_e1) + 10'(w_e2) - 10'd127;
      w_mid_in.prod = 48'({1'b1, op1[22:0]}) * 48'({1'b1, op2[22:0]});
      w_mid_in.tag  = in_tag;
   end

   if (LATENCY > 1) begin : g_pipe
      localparam int NM = LATENCY - 1;
      mid_t          r_mid [NM];
      logic [NM-1:0] r_vld;
      always_ff @(posedge clk) begin
         if (rst) r_vld <= '0;
         else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_mid[0] <= w_mid_in;
            for (int i = 1; i < NM; i++) begin
               r_vld[i] <= r_vld[i-1];
               r_mid[i] <= r_mid[i-1];
            end
         end
      end
      assign w_mid_out = r_mid[NM-1];
      assign w_vld     = r_vld[NM-1];
   end else begin : g_comb
      assign w_mid_out = w_mid_in;
      assign w_vld     = in_valid;
   end

   // normalise so the leading one sits above bit 46, then round to nearest even
   assign w_norm = w_mid_out.prod[47] ? w_mid_out.prod[46:0] : {w_mid_out.prod[45:0], 1'b0};
   assign w_up   = w_norm[23] && (w_norm[24] || |w_norm[22:0]);
   assign w_rnd  = {1'b0, w_norm[46:24]} + 24'(w_up);
   assign w_fexp = w_mid_out.exp + 10'(w_mid_out.prod[47]) + 10'(w_rnd[23]);

   always_comb begin
      w_flg = 3'b000;
      w_res = {w_mid_out.sign, w_fexp[7:0], w_rnd[22:0]};
      if (w_mid_out.kind == 2'd3) begin
         w_res = 32'h7FC0_0000;
         w_flg = 3'b001;
      end else if (w_mid_out.kind == 2'd2) w_res = {w_mid_out.sign, 8'hFF, 23'h0};
      else if (w_mid_out.kind == 2'd1) w_res = {w_mid_out.sign, 31'h0};
      else if (w_fexp >= 10'sd255) begin
         w_res = {w_mid_out.sign, 8'hFF, 23'h0};
         w_flg = 3'b100;
      end else if (w_fexp <= 10'sd0) begin
         w_res = {w_mid_out.sign, 31'h0};
         w_flg = 3'b010;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         result          <= 32'h0;
         out_tag         <= '0;
         {ovf, udf, nv}  <= 3'b000;
      end else if (w_adv) begin
         out_valid       <= w_vld;
         result          <= w_res;
         out_tag         <= w_mid_out.tag;
         {ovf, udf, nv}  <= w_vld ? w_flg : 3'b000;
      end
   end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: drives LATENCY=1,3,4 instances with one stimulus stream and checks
// each against a real-arithmetic reference model through per-instance expectation queues.
module tb_fmul_pipe;
   localparam int TW = 6;
   localparam int N  = 3;

   typedef struct {
      logic [31:0]   r;
      logic [2:0]    f;
      logic [TW-1:0] t;
      bit            lat;
      int            c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]          iv, ir, ov, ovf, udf, nv;
   logic                  out_ready;
   logic [31:0]           op1, op2;
   logic [TW-1:0]         tag;
   logic [N-1:0][31:0]    res;
   logic [N-1:0][TW-1:0]  otag;
   bit                    rnd_bp = 0;
   int                    pass_cnt = 0, tot = 0, cyc = 0;
   exp_t                  q [N][$];

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < N; k++) begin : g
      localparam int L = (k == 0) ? 1 : k + 2;
      fmul_pipe #(.LATENCY(L), .TAG_W(TW)) dut (
         .clk(clk), .rst(rst), .in_valid(iv[k]), .in_ready(ir[k]),
         .op1(op1), .op2(op2), .in_tag(tag),
         .out_valid(ov[k]), .out_ready(out_ready), .result(res[k]), .out_tag(otag[k]),
         .ovf(ovf[k]), .udf(udf[k]), .nv(nv[k])
      );
      always @(negedge clk) begin : cmp
         exp_t e;
         if (!rst) begin
            tot++;
            if (ir[k] === !(ov[k] && !out_ready)) pass_cnt++;
            else $display("FAIL L%0d in_ready: got %b want %b", L, ir[k], !(ov[k] && !out_ready));
            if (ov[k] && out_ready) begin
               tot++;
               if (q[k].size() == 0) $display("FAIL L%0d spurious out_valid: got tag %0d want none", L, otag[k]);
               else begin
                  e = q[k].pop_front();
                  if ({res[k], ovf[k], udf[k], nv[k], otag[k]} === {e.r, e.f, e.t}) pass_cnt++;
                  else $display("FAIL L%0d result: got %h/%b/tag%0d want %h/%b/tag%0d",
                                L, res[k], {ovf[k], udf[k], nv[k]}, otag[k], e.r, e.f, e.t);
                  if (e.lat) begin
                     tot++;
                     if (cyc - e.c == L) pass_cnt++;
                     else $display("FAIL L%0d latency: got %0d want %0d", L, cyc - e.c, L);
                  end
               end
            end
         end
      end
   end

   // exact product in double precision, then rounded to single by hand; returns {result, ovf, udf, nv}
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      logic        s  = a[31] ^ b[31];
      bit          za = a[30:23] == 8'h00, zb = b[30:23] == 8'h00;
      bit          ia = a[30:0] == 31'h7F800000, ib = b[30:0] == 31'h7F800000;
      bit          na = a[30:23] == 8'hFF && !ia, nb = b[30:23] == 8'hFF && !ib;
      real         p;
      logic [63:0] bits;
      logic [24:0] m;
      logic [28:0] rem;
      int          e;
      if (na || nb || (ia && zb) || (ib && za)) return {32'h7FC00000, 3'b001};
      if (ia || ib) return {s, 8'hFF, 23'h0, 3'b000};
      if (za || zb) return {s, 31'h0, 3'b000};
      p    = $bitstoreal({1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'h0}) *
             $bitstoreal({1'b0, 11'(b[30:23]) + 11'd896, b[22:0], 29'h0});
      bits = $realtobits(p);
      e    = int'(bits[62:52]) - 896;
      m    = {2'b01, bits[51:29]};
      rem  = bits[28:0];
      if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 3'b100};
      if (e <= 0) return {s, 31'h0, 3'b010};
      return {s, 8'(e), m[22:0], 3'b000};
   endfunction

   function automatic logic [31:0] rnd_op();
      int unsigned r = $urandom_range(0, 19);
      logic [31:0] x = {1'($urandom), 8'(r < 10 ? $urandom_range(100, 154) : $urandom_range(1, 254)), 23'($urandom)};
      return r == 0 ? {x[31], 31'h0} : r == 1 ? {x[31], 31'h7F800000} :
             r == 2 ? {x[31], 8'hFF, 1'b1, x[21:0]} : r == 3 ? {x[31], 8'h00, x[22:1], 1'b1} : x;
   endfunction

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tot++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %h want %h", n, a, e);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t, input bit lat);
      logic [34:0]  m    = model(a, b);
      logic [N-1:0] done = '0;
      int           n    = 0;
      op1 = a;
      op2 = b;
      tag = t;
      iv  = '1;
      while (done != '1) begin
         @(negedge clk);
         for (int k = 0; k < N; k++)
            if (iv[k] && ir[k]) begin
               q[k].push_back('{m[34:3], m[2:0], t, lat, cyc});
               done[k] = 1'b1;
            end
         @(posedge clk);
         #1;
         iv = ~done;
         if (rnd_bp) out_ready = ($urandom_range(0, 2) != 0);
         n++;
         if (n > 200) begin
            tot++;
            $display("FAIL send timeout: got accepted %b want %b", done, {N{1'b1}});
            break;
         end
      end
      iv = '0;
   endtask

   task automatic drain();
      int n = 0;
      while (q[0].size() + q[1].size() + q[2].size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) begin
         tot++;
         $display("FAIL drain timeout: got %0d pending want 0", q[0].size() + q[1].size() + q[2].size());
      end
      @(posedge clk);
      #1;
   endtask

   logic [31:0] da [9] = '{32'h3FC00000, 32'h7F000000, 32'hFF000000, 32'h7F800000, 32'h7FC00000,
                           32'h7F800000, 32'h00800000, 32'h00000001, 32'h3F800001};
   logic [31:0] db [9] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000,
                           32'hBF800000, 32'h3F000000, 32'h40000000, 32'h3F7FFFFF};
   logic [34:0] dx [9] = '{{32'h40400000, 3'b000}, {32'h7F800000, 3'b100}, {32'hFF800000, 3'b100},
                           {32'h7FC00000, 3'b001}, {32'h7FC00000, 3'b001}, {32'hFF800000, 3'b000},
                           {32'h00000000, 3'b010}, {32'h00000000, 3'b000}, {32'h3F800000, 3'b000}};

   initial begin
      iv        = '0;
      op1       = '0;
      op2       = '0;
      tag       = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(ov), 64'(0));
      chk("rst_in_ready", 64'(ir), 64'({N{1'b1}}));
      chk("rst_flags", 64'({ovf, udf, nv}), 64'(0));
      for (int k = 0; k < N; k++) chk("rst_result_tag", {res[k], 26'(otag[k])}, 64'(0));
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         chk("model_pin", 64'(model(da[i], db[i])), 64'(dx[i]));
         send(da[i], db[i], TW'(i), 1'b1);
         drain();
      end
      // backpressure: stall the consumer for 5 cycles in the middle of a 16-op stream
      fork
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 16; i++) send(rnd_op(), rnd_op(), TW'(i), 1'b0);
      drain();
      // reset with operations in flight
      for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), TW'(40 + i), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < N; k++) q[k].delete();
      repeat (10) begin
         @(negedge clk);
         chk("rst_flush_out_valid", 64'(ov), 64'(0));
      end
      @(posedge clk);
      #1 rnd_bp = 1;
      for (int i = 0; i < 3000; i++) send(rnd_op(), rnd_op(), TW'(i), 1'b0);
      rnd_bp    = 0;
      out_ready = 1'b1;
      drain();
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule
